// File: rtl/run_monitor.sv
// End-of-test monitor and performance counter that watches a riscv core.
// Latency: all outputs registered; every sampled event shows up one edge later.
// Backpressure: none; the monitor only observes and never stalls the core.
//
// Ports:
//   clk, rst_n        core clock and asynchronous active-low reset
//   start, clear      single-cycle start pulse, synchronous clear to IDLE
//   pc, retire_valid, stall, mem_we, mem_addr, mem_wdata
//                     observed core activity
//   running, done     state == RUN / state == DONE
//   result            0 none, 1 pass, 2 fail, 3 hang, 4 timeout
//   exit_code         failing test number (store data >> 1), 0 on pass
//   cycle_cnt, instr_cnt, stall_cnt
//                     saturating counters of RUN cycles, retires and stalls
module run_monitor #(
    parameter int                XLEN        = 32,
    parameter int                CNT_W       = 32,
    parameter int                TIMEOUT     = 10000,
    parameter int                HANG_LIMIT  = 16,
    parameter logic [XLEN-1:0]   TOHOST_ADDR = 32'h0000_0FFC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [XLEN-1:0]   pc,
    input  logic              retire_valid,
    input  logic              stall,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              running,
    output logic              done,
    output logic [2:0]        result,
    output logic [XLEN-2:0]   exit_code,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [2:0] RES_NONE    = 3'd0;
    localparam logic [2:0] RES_PASS    = 3'd1;
    localparam logic [2:0] RES_FAIL    = 3'd2;
    localparam logic [2:0] RES_HANG    = 3'd3;
    localparam logic [2:0] RES_TIMEOUT = 3'd4;

    // The match and watchdog counters never need to hold their limit value:
    // the cycle that would reach it terminates the run instead.
    localparam int HC_W = $clog2(HANG_LIMIT);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HANG_LIMIT - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [XLEN-1:0]  prev_pc;
    logic             have_prev;   // low on the first RUN cycle: no previous pc yet
    logic [HC_W-1:0]  match_cnt;   // consecutive unchanged-pc cycles seen so far
    logic [WD_W-1:0]  wd_cnt;      // RUN cycles before the current one

    // The watchdog has its own counter because cycle_cnt may saturate
    // below TIMEOUT when CNT_W is narrow.
    logic tohost_hit;
    logic pc_same;
    logic hang_hit;
    logic timeout_hit;

    always_comb begin
        tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
        pc_same     = have_prev && (pc == prev_pc);
        hang_hit    = pc_same && (match_cnt == HC_LAST);
        timeout_hit = (wd_cnt == WD_LAST);
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            result    <= RES_NONE;
            exit_code <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
            prev_pc   <= '0;
            have_prev <= 1'b0;
            match_cnt <= '0;
            wd_cnt    <= '0;
        end else if (clear) begin
            // clear wins over start and any termination in the same cycle
            state     <= S_IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            result    <= RES_NONE;
            exit_code <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
            have_prev <= 1'b0;
            match_cnt <= '0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        running   <= 1'b1;
                        have_prev <= 1'b0;
                        match_cnt <= '0;
                        wd_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    // the terminating cycle is counted like any other
                    cycle_cnt <= sat_inc(cycle_cnt, 1'b1);
                    instr_cnt <= sat_inc(instr_cnt, retire_valid);
                    stall_cnt <= sat_inc(stall_cnt, stall);
                    prev_pc   <= pc;
                    have_prev <= 1'b1;
                    match_cnt <= pc_same ? match_cnt + HC_W'(1) : '0;
                    wd_cnt    <= wd_cnt + WD_W'(1);
                    if (tohost_hit || hang_hit || timeout_hit) begin
                        state   <= S_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                    if (tohost_hit) begin
                        if (mem_wdata == XLEN'(1)) begin
                            result    <= RES_PASS;
                            exit_code <= '0;
                        end else begin
                            result    <= RES_FAIL;
                            exit_code <= mem_wdata[XLEN-1:1];
                        end
                    end else if (hang_hit) begin
                        result <= RES_HANG;
                    end else if (timeout_hit) begin
                        result <= RES_TIMEOUT;
                    end
                end
                default: begin
                    // S_DONE: everything frozen until clear
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic        clear;
    logic [31:0] pc;
    logic        retire_valid;
    logic        stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic        running, done;
    logic [2:0]  result;
    logic [30:0] exit_code;
    logic [31:0] cycle_cnt, instr_cnt, stall_cnt;

    logic        running2, done2;
    logic [2:0]  result2;
    logic [30:0] exit_code2;
    logic [3:0]  cycle_cnt2, instr_cnt2, stall_cnt2;

    int checks = 0;
    int errors = 0;

    run_monitor #(.XLEN(32), .CNT_W(32), .TIMEOUT(100), .HANG_LIMIT(16),
                  .TOHOST_ADDR(32'h0000_0FFC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .pc(pc),
        .retire_valid(retire_valid), .stall(stall), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .running(running),
        .done(done), .result(result), .exit_code(exit_code),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    run_monitor #(.XLEN(32), .CNT_W(4), .TIMEOUT(50), .HANG_LIMIT(16),
                  .TOHOST_ADDR(32'h0000_0FFC)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .clear(clear), .pc(pc),
        .retire_valid(retire_valid), .stall(stall), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .running(running2),
        .done(done2), .result(result2), .exit_code(exit_code2),
        .cycle_cnt(cycle_cnt2), .instr_cnt(instr_cnt2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_and_start();
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({running, done, result, exit_code} !== '0) begin
            errors++;
            $display("FAIL reset_flags: got run=%0b done=%0b res=%0d exit=%0d required all 0",
                     running, done, result, exit_code);
        end
        checks++;
        if ({cycle_cnt, instr_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d/%0d required 0/0/0",
                     cycle_cnt, instr_cnt, stall_cnt);
        end
        #10;
        rst_n = 1'b1;
    endtask

    task automatic test_pass();
        clear_and_start();
        for (int c = 1; c <= 40; c++) begin
            pc = 32'(4 * c);
            retire_valid = (c <= 30);
            stall = (c > 30 && c <= 35);
            step();
        end
        retire_valid = 1'b0;
        stall = 1'b0;
        checks++;
        if (running !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL pass_running: got run=%0b done=%0b required 1/0", running, done);
        end
        pc = 32'd164;
        mem_we = 1'b1;
        mem_addr = 32'h0000_0FFC;
        mem_wdata = 32'd1;
        step();
        mem_we = 1'b0;
        checks++;
        if (done !== 1'b1 || running !== 1'b0 || result !== 3'd1 || exit_code !== 31'd0) begin
            errors++;
            $display("FAIL pass_result: got done=%0b run=%0b res=%0d exit=%0d required 1/0/1/0",
                     done, running, result, exit_code);
        end
        checks++;
        if (cycle_cnt !== 32'd41 || instr_cnt !== 32'd30 || stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL pass_counters: got %0d/%0d/%0d required 41/30/5",
                     cycle_cnt, instr_cnt, stall_cnt);
        end
        pc = 32'd500;
        retire_valid = 1'b1;
        stall = 1'b1;
        step();
        retire_valid = 1'b0;
        stall = 1'b0;
        checks++;
        if (cycle_cnt !== 32'd41 || instr_cnt !== 32'd30 || stall_cnt !== 32'd5 || result !== 3'd1) begin
            errors++;
            $display("FAIL done_frozen: got %0d/%0d/%0d res=%0d required 41/30/5 res=1",
                     cycle_cnt, instr_cnt, stall_cnt, result);
        end
    endtask

    task automatic test_fail();
        clear_and_start();
        pc = 32'd4;
        step();
        pc = 32'd8;
        mem_we = 1'b1;
        mem_addr = 32'h0000_0FF8;
        mem_wdata = 32'd7;
        step();
        checks++;
        if (running !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL fail_wrong_addr: got run=%0b done=%0b required 1/0", running, done);
        end
        pc = 32'd12;
        mem_addr = 32'h0000_0FFC;
        step();
        mem_we = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 3'd2 || exit_code !== 31'd3 || cycle_cnt !== 32'd3) begin
            errors++;
            $display("FAIL fail_result: got done=%0b res=%0d exit=%0d cyc=%0d required 1/2/3/3",
                     done, result, exit_code, cycle_cnt);
        end
    endtask

    task automatic test_hang();
        clear_and_start();
        // pc steps until cycle 10, holds, glitches once at cycle 18, holds again from 19
        for (int c = 1; c <= 35; c++) begin
            if (c <= 10)       pc = 32'(4 * c);
            else if (c == 18)  pc = 32'h100;
            else               pc = 32'd40;
            step();
            if (c == 26 || c == 34) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL hang_early_c%0d: got done=%0b res=%0d required done=0",
                             c, done, result);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || result !== 3'd3 || cycle_cnt !== 32'd35) begin
            errors++;
            $display("FAIL hang_result: got done=%0b res=%0d cyc=%0d required 1/3/35",
                     done, result, cycle_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_and_start();
        for (int c = 1; c <= 99; c++) begin
            pc = 32'(4 * c);
            step();
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got done=%0b required 0", done);
        end
        pc = 32'd400;
        step();
        checks++;
        if (done !== 1'b1 || result !== 3'd4 || cycle_cnt !== 32'd100) begin
            errors++;
            $display("FAIL timeout_result: got done=%0b res=%0d cyc=%0d required 1/4/100",
                     done, result, cycle_cnt);
        end
    endtask

    task automatic test_start_in_done();
        start = 1'b1;
        pc = 32'd1000;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || running !== 1'b0 || result !== 3'd4 || cycle_cnt !== 32'd100) begin
            errors++;
            $display("FAIL start_in_done: got done=%0b run=%0b res=%0d cyc=%0d required 1/0/4/100",
                     done, running, result, cycle_cnt);
        end
    endtask

    task automatic test_priority();
        clear_and_start();
        // pc holds from cycle 84 so the hang and the watchdog both fire at cycle 100
        for (int c = 1; c <= 99; c++) begin
            pc = (c <= 84) ? 32'(4 * c) : 32'd336;
            step();
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL prio_early: got done=%0b required 0", done);
        end
        pc = 32'd336;
        mem_we = 1'b1;
        mem_addr = 32'h0000_0FFC;
        mem_wdata = 32'd1;
        step();
        mem_we = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 3'd1 || cycle_cnt !== 32'd100) begin
            errors++;
            $display("FAIL prio_result: got done=%0b res=%0d cyc=%0d required 1/1/100",
                     done, result, cycle_cnt);
        end
    endtask

    task automatic test_clear_start();
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        checks++;
        if (running !== 1'b0 || done !== 1'b0 || result !== 3'd0 || cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL clear_start: got run=%0b done=%0b res=%0d cyc=%0d required 0/0/0/0",
                     running, done, result, cycle_cnt);
        end
        pc = 32'd8;
        step();
        checks++;
        if (running !== 1'b0 || cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL clear_start_idle: got run=%0b cyc=%0d required 0/0", running, cycle_cnt);
        end
    endtask

    task automatic test_async_reset();
        clear_and_start();
        for (int c = 1; c <= 5; c++) begin
            pc = 32'(4 * c);
            retire_valid = 1'b1;
            step();
        end
        retire_valid = 1'b0;
        checks++;
        if (running !== 1'b1 || cycle_cnt !== 32'd5) begin
            errors++;
            $display("FAIL areset_pre: got run=%0b cyc=%0d required 1/5", running, cycle_cnt);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({running, done, result, exit_code, cycle_cnt, instr_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL areset_clear: got run=%0b cyc=%0d ins=%0d required 0/0/0",
                     running, cycle_cnt, instr_cnt);
        end
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        pc = 32'd100;
        step();
        checks++;
        if (running !== 1'b1 || cycle_cnt !== 32'd1) begin
            errors++;
            $display("FAIL areset_restart: got run=%0b cyc=%0d required 1/1", running, cycle_cnt);
        end
    endtask

    task automatic test_saturation();
        clear = 1'b1;
        step();
        clear = 1'b0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        retire_valid = 1'b1;
        for (int c = 1; c <= 49; c++) begin
            pc = 32'(4 * c);
            step();
        end
        checks++;
        if (done2 !== 1'b0 || instr_cnt2 !== 4'd15) begin
            errors++;
            $display("FAIL sat_early: got done=%0b ins=%0d required 0/15", done2, instr_cnt2);
        end
        pc = 32'd200;
        step();
        retire_valid = 1'b0;
        checks++;
        if (done2 !== 1'b1 || result2 !== 3'd4 || instr_cnt2 !== 4'd15 || cycle_cnt2 !== 4'd15) begin
            errors++;
            $display("FAIL sat_result: got done=%0b res=%0d ins=%0d cyc=%0d required 1/4/15/15",
                     done2, result2, instr_cnt2, cycle_cnt2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        clear = 1'b0;
        pc = '0;
        retire_valid = 1'b0;
        stall = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;

        test_reset();
        test_pass();
        test_fail();
        test_hang();
        test_timeout();
        test_start_in_done();
        test_priority();
        test_clear_start();
        test_async_reset();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
